// File: rtl/cam_bram_ram_arbiter_if.sv
// Requester-side bus for the CAM block-RAM arbiter: two valid/ready request
// channels plus their tagged read-response strobes and the shared read data.
interface cam_bram_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 72,
    parameter int MASK_WIDTH = 72
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [MASK_WIDTH-1:0] req0_mask;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [MASK_WIDTH-1:0] req1_mask;

    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_mask,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_mask,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_mask,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_mask,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata
    );
endinterface

// File: rtl/cam_bram_ram_arbiter.sv
// Round-robin arbiter and sequencer for one single-port block RAM of the CAM
// array. Shares the port between two requesters, tags read responses back to
// the issuer across the RAM's 1- or 2-cycle read latency, and zero-fills the
// whole array after reset or on command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to every word, one per cycle; no grants
// ST_RUN   | normal operation, round-robin grants to the requesters
module cam_bram_ram_arbiter #(
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_DEPTH      = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH     = 72,
    parameter int MASK_WIDTH     = 72,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    cam_bram_ram_arbiter_if.slave  req_if,
    input  logic                   clear_start,
    output logic                   init_done,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_chip_en,
    output logic                   ram_wr_en,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    output logic [MASK_WIDTH-1:0]  ram_mask,
    output logic                   ram_reg_en,
    input  logic [DATA_WIDTH-1:0]  ram_rdata
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_nxt;
    logic                  ptr;
    logic                  ptr_nxt;

    logic                  in_run;
    logic                  in_clear;
    logic                  fire0;
    logic                  fire1;
    logic                  fire_rd;

    logic [RD_LATENCY:1]   pipe_vld;
    logic [RD_LATENCY:1]   pipe_id;

    // Grants are gated by rst as well as state so the readies and RAM strobes
    // drop the moment reset asserts, whatever state the FSM was in.
    assign in_run   = (state == ST_RUN)   && !rst;
    assign in_clear = (state == ST_CLEAR) && !rst;

    // A requester is only held off when the other one is valid and holds priority.
    assign req_if.req0_ready = in_run && !(req_if.req1_valid && ptr);
    assign req_if.req1_ready = in_run && !(req_if.req0_valid && !ptr);

    assign fire0   = req_if.req0_valid && req_if.req0_ready;
    assign fire1   = req_if.req1_valid && req_if.req1_ready;
    assign fire_rd = (fire0 && !req_if.req0_we) || (fire1 && !req_if.req1_we);

    assign init_done = (state == ST_RUN);

    // State, clear counter and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            ptr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Next state plus the RAM pin drive: clear sweep, winning request, or idle.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ptr_nxt     = ptr;
        ram_chip_en = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_mask    = '0;

        case (state)
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = ST_RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: state_nxt = RESET_STATE;
        endcase

        if (in_clear) begin
            ram_chip_en = 1'b1;
            ram_wr_en   = 1'b1;
            ram_addr    = clr_cnt;
            ram_mask    = '1;
        end else if (fire0) begin
            ram_chip_en = 1'b1;
            ram_wr_en   = req_if.req0_we;
            ram_addr    = req_if.req0_addr;
            ram_wdata   = req_if.req0_wdata;
            ram_mask    = req_if.req0_mask;
            ptr_nxt     = 1'b1;
        end else if (fire1) begin
            ram_chip_en = 1'b1;
            ram_wr_en   = req_if.req1_we;
            ram_addr    = req_if.req1_addr;
            ram_wdata   = req_if.req1_wdata;
            ram_mask    = req_if.req1_mask;
            ptr_nxt     = 1'b0;
        end
    end

    // Read tag pipeline, one stage per cycle of RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[1] <= fire_rd;
            pipe_id[1]  <= fire1;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    assign req_if.rsp0_valid = pipe_vld[RD_LATENCY] && !pipe_id[RD_LATENCY];
    assign req_if.rsp1_valid = pipe_vld[RD_LATENCY] &&  pipe_id[RD_LATENCY];
    assign req_if.rsp_rdata  = ram_rdata;

    // The RAM output register only exists on the two-cycle macro; it loads
    // one cycle after the array read.
    if (RD_LATENCY >= 2) begin : g_reg_en
        assign ram_reg_en = pipe_vld[1];
    end else begin : g_no_reg_en
        assign ram_reg_en = 1'b0;
    end

endmodule

// File: tb/tb_cam_bram_ram_arbiter.sv
// Bench for cam_bram_ram_arbiter. Instance A: 1-cycle RAM, clear on reset.
// Instance B: 2-cycle RAM, starts in RUN. Each has a behavioural RAM and a
// reference memory; read expectations are queued on fire and checked when
// the tagged response appears.
module tb_cam_bram_ram_arbiter;
    localparam int AW    = 9;
    localparam int DW    = 72;
    localparam int MW    = 72;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        bit          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    logic [DW-1:0] ref_a [DEPTH];
    logic [DW-1:0] ref_b [DEPTH];

    // ---------------- instance A ----------------
    cam_bram_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) ia ();
    logic          a_clear_start;
    logic          a_init_done;
    logic [AW-1:0] a_addr;
    logic          a_chip_en;
    logic          a_wr_en;
    logic [DW-1:0] a_wdata;
    logic [MW-1:0] a_mask;
    logic          a_reg_en;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] mem_a [DEPTH];

    cam_bram_ram_arbiter #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                           .RD_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .req_if(ia), .clear_start(a_clear_start), .init_done(a_init_done),
        .ram_addr(a_addr), .ram_chip_en(a_chip_en), .ram_wr_en(a_wr_en), .ram_wdata(a_wdata),
        .ram_mask(a_mask), .ram_reg_en(a_reg_en), .ram_rdata(a_rdata)
    );

    always @(posedge clk) begin
        if (a_chip_en) begin
            if (a_wr_en) mem_a[a_addr] <= (mem_a[a_addr] & ~a_mask) | (a_wdata & a_mask);
            else         a_rdata <= mem_a[a_addr];
        end
    end

    // ---------------- instance B ----------------
    cam_bram_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) ib ();
    logic          b_clear_start;
    logic          b_init_done;
    logic [AW-1:0] b_addr;
    logic          b_chip_en;
    logic          b_wr_en;
    logic [DW-1:0] b_wdata;
    logic [MW-1:0] b_mask;
    logic          b_reg_en;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] b_rd1;
    logic [DW-1:0] mem_b [DEPTH];

    cam_bram_ram_arbiter #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                           .RD_LATENCY(2), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .rst(rst), .req_if(ib), .clear_start(b_clear_start), .init_done(b_init_done),
        .ram_addr(b_addr), .ram_chip_en(b_chip_en), .ram_wr_en(b_wr_en), .ram_wdata(b_wdata),
        .ram_mask(b_mask), .ram_reg_en(b_reg_en), .ram_rdata(b_rdata)
    );

    always @(posedge clk) begin
        if (b_chip_en) begin
            if (b_wr_en) mem_b[b_addr] <= (mem_b[b_addr] & ~b_mask) | (b_wdata & b_mask);
            else         b_rd1 <= mem_b[b_addr];
        end
        if (b_reg_en) b_rdata <= b_rd1;
    end

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        #4;
        if (rst) begin
            qa.delete();
            ref_a = '{default: '0};
        end else begin
            if (ia.rsp0_valid || ia.rsp1_valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_rsp_unexpected cyc=%0d rsp0=%b rsp1=%b required no response", cyc, ia.rsp0_valid, ia.rsp1_valid);
                end else begin
                    ea = qa.pop_front();
                    if (cyc != ea.due || ia.rsp0_valid !== (ea.id == 1'b0) || ia.rsp1_valid !== (ea.id == 1'b1) || ia.rsp_rdata !== ea.data) begin
                        errors++;
                        $display("FAIL a_rsp cyc=%0d rsp0=%b rsp1=%b data=%h required cyc=%0d id=%0d data=%h",
                                 cyc, ia.rsp0_valid, ia.rsp1_valid, ia.rsp_rdata, ea.due, ea.id, ea.data);
                    end
                end
            end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL a_rsp_missing cyc=%0d got none required id=%0d at cyc=%0d", cyc, qa[0].id, qa[0].due);
                void'(qa.pop_front());
            end
            if (ia.req0_valid && ia.req0_ready) begin
                if (ia.req0_we) ref_a[ia.req0_addr] = (ref_a[ia.req0_addr] & ~ia.req0_mask) | (ia.req0_wdata & ia.req0_mask);
                else            qa.push_back('{due: cyc + 1, id: 1'b0, data: ref_a[ia.req0_addr]});
            end
            if (ia.req1_valid && ia.req1_ready) begin
                if (ia.req1_we) ref_a[ia.req1_addr] = (ref_a[ia.req1_addr] & ~ia.req1_mask) | (ia.req1_wdata & ia.req1_mask);
                else            qa.push_back('{due: cyc + 1, id: 1'b1, data: ref_a[ia.req1_addr]});
            end
            if (a_clear_start) ref_a = '{default: '0};
        end
    end

    always @(negedge clk) begin
        #4;
        if (rst) begin
            qb.delete();
        end else begin
            if (ib.rsp0_valid || ib.rsp1_valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_rsp_unexpected cyc=%0d rsp0=%b rsp1=%b required no response", cyc, ib.rsp0_valid, ib.rsp1_valid);
                end else begin
                    eb = qb.pop_front();
                    if (cyc != eb.due || ib.rsp0_valid !== (eb.id == 1'b0) || ib.rsp1_valid !== (eb.id == 1'b1) || ib.rsp_rdata !== eb.data) begin
                        errors++;
                        $display("FAIL b_rsp cyc=%0d rsp0=%b rsp1=%b data=%h required cyc=%0d id=%0d data=%h",
                                 cyc, ib.rsp0_valid, ib.rsp1_valid, ib.rsp_rdata, eb.due, eb.id, eb.data);
                    end
                end
            end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL b_rsp_missing cyc=%0d got none required id=%0d at cyc=%0d", cyc, qb[0].id, qb[0].due);
                void'(qb.pop_front());
            end
            if (ib.req0_valid && ib.req0_ready) begin
                if (ib.req0_we) ref_b[ib.req0_addr] = (ref_b[ib.req0_addr] & ~ib.req0_mask) | (ib.req0_wdata & ib.req0_mask);
                else            qb.push_back('{due: cyc + 2, id: 1'b0, data: ref_b[ib.req0_addr]});
            end
            if (ib.req1_valid && ib.req1_ready) begin
                if (ib.req1_we) ref_b[ib.req1_addr] = (ref_b[ib.req1_addr] & ~ib.req1_mask) | (ib.req1_wdata & ib.req1_mask);
                else            qb.push_back('{due: cyc + 2, id: 1'b1, data: ref_b[ib.req1_addr]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_a(input bit p, input bit v, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [MW-1:0] mk);
        if (p == 1'b0) begin
            ia.req0_valid = v; ia.req0_we = we; ia.req0_addr = addr; ia.req0_wdata = wd; ia.req0_mask = mk;
        end else begin
            ia.req1_valid = v; ia.req1_we = we; ia.req1_addr = addr; ia.req1_wdata = wd; ia.req1_mask = mk;
        end
    endtask

    task automatic drive_b(input bit p, input bit v, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [MW-1:0] mk);
        if (p == 1'b0) begin
            ib.req0_valid = v; ib.req0_we = we; ib.req0_addr = addr; ib.req0_wdata = wd; ib.req0_mask = mk;
        end else begin
            ib.req1_valid = v; ib.req1_we = we; ib.req1_addr = addr; ib.req1_wdata = wd; ib.req1_mask = mk;
        end
    endtask

    // Called at the negedge of the first clear cycle; pulses clear_start midway,
    // which must not restart the sweep.
    task automatic check_clear_sweep(input string name);
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) @(negedge clk);
            a_clear_start = (k == 300);
            #1;
            checks++;
            if ({a_chip_en, a_wr_en, a_addr, a_wdata, a_mask, ia.req0_ready, ia.req1_ready, a_init_done} !==
                {1'b1, 1'b1, AW'(k), {DW{1'b0}}, {MW{1'b1}}, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s_sweep k=%0d en=%b we=%b addr=%0d wdata=%h rdy=%b%b done=%b required en=1 we=1 addr=%0d wdata=0 rdy=00 done=0",
                         name, k, a_chip_en, a_wr_en, a_addr, a_wdata, ia.req0_ready, ia.req1_ready, a_init_done, k);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_init_done got %b required 1 after %0d clear cycles", name, a_init_done, DEPTH);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_clear_start = 1'b0;
        b_clear_start = 1'b0;
        drive_a(0, 1, 0, '0, '0, '0);
        drive_a(1, 1, 0, '0, '0, '0);
        drive_b(0, 1, 0, '0, '0, '0);
        drive_b(1, 1, 0, '0, '0, '0);
        @(negedge clk);
        #1;
        checks++;
        if ({ia.req0_ready, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid, a_chip_en, a_wr_en, a_reg_en, a_init_done} !== 8'b0) begin
            errors++;
            $display("FAIL reset_a rdy=%b%b rsp=%b%b en=%b we=%b reg=%b done=%b required all 0",
                     ia.req0_ready, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid, a_chip_en, a_wr_en, a_reg_en, a_init_done);
        end
        checks++;
        if ({ib.req0_ready, ib.req1_ready, ib.rsp0_valid, ib.rsp1_valid, b_chip_en, b_wr_en, b_reg_en, b_init_done} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_b rdy=%b%b rsp=%b%b en=%b we=%b reg=%b done=%b required done=1 rest 0",
                     ib.req0_ready, ib.req1_ready, ib.rsp0_valid, ib.rsp1_valid, b_chip_en, b_wr_en, b_reg_en, b_init_done);
        end
        drive_a(1, 0, 0, '0, '0, '0);
        drive_b(0, 0, 0, '0, '0, '0);
        drive_b(1, 0, 0, '0, '0, '0);
        // port0 of A keeps a read of the last address pending across the sweep
        drive_a(0, 1, 0, AW'(DEPTH - 1), '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset_clear();
        rst = 1'b0;
        check_clear_sweep("reset_clear");
        checks++;
        if (ia.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_clear_run_ready got %b required 1", ia.req0_ready);
        end
        @(negedge clk);
        drive_a(0, 0, 0, '0, '0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        drive_a(0, 1, 1, 9'h010, 72'hA5, '1);
        #1;
        checks++;
        if ({ia.req0_ready, a_chip_en, a_wr_en, a_addr, a_wdata} !== {1'b1, 1'b1, 1'b1, 9'h010, 72'hA5}) begin
            errors++;
            $display("FAIL wr_drive rdy=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 010 a5",
                     ia.req0_ready, a_chip_en, a_wr_en, a_addr, a_wdata);
        end
        @(negedge clk);
        drive_a(0, 1, 0, 9'h010, '0, '0);
        #1;
        checks++;
        if ({a_chip_en, a_wr_en, a_addr} !== {1'b1, 1'b0, 9'h010}) begin
            errors++;
            $display("FAIL rd_drive en=%b we=%b addr=%h required 1 0 010", a_chip_en, a_wr_en, a_addr);
        end
        @(negedge clk);
        drive_a(0, 0, 0, '0, '0, '0);
        #1;
        checks++;
        if ({ia.rsp0_valid, ia.rsp1_valid, ia.rsp_rdata, a_chip_en, a_wr_en} !== {1'b1, 1'b0, 72'hA5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_rd_rsp rsp=%b%b data=%h en=%b we=%b required 10 a5 0 0",
                     ia.rsp0_valid, ia.rsp1_valid, ia.rsp_rdata, a_chip_en, a_wr_en);
        end
        // masked write only updates the low byte
        @(negedge clk);
        drive_a(0, 1, 1, 9'h011, 72'h123456, '1);
        @(negedge clk);
        drive_a(0, 1, 1, 9'h011, 72'hFFFFFF, 72'hFF);
        @(negedge clk);
        drive_a(0, 1, 0, 9'h011, '0, '0);
        @(negedge clk);
        drive_a(0, 0, 0, '0, '0, '0);
        #1;
        checks++;
        if (ia.rsp_rdata !== 72'h1234FF) begin
            errors++;
            $display("FAIL masked_write data=%h required 1234ff", ia.rsp_rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        drive_a(0, 1, 1, 9'h001, 72'h1111_0001, '1);
        @(negedge clk);
        drive_a(0, 0, 0, '0, '0, '0);
        drive_a(1, 1, 1, 9'h002, 72'h2222_0002, '1);
        @(negedge clk);
        drive_a(0, 1, 0, 9'h001, '0, '0);
        drive_a(1, 1, 0, 9'h002, '0, '0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if ({ia.req0_ready, ia.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant i=%0d rdy=%b%b required %s", i, ia.req0_ready, ia.req1_ready,
                         (i % 2 == 0) ? "10" : "01");
            end
        end
        @(negedge clk);
        drive_a(0, 0, 0, '0, '0, '0);
        drive_a(1, 0, 0, '0, '0, '0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clear_cmd();
        drive_a(0, 1, 1, 9'h020, 72'hDEAD, '1);
        @(negedge clk);
        drive_a(0, 1, 0, 9'h020, '0, '0);
        a_clear_start = 1'b1;
        #1;
        checks++;
        if ({ia.req0_ready, a_init_done} !== 2'b11) begin
            errors++;
            $display("FAIL clear_cmd_fire rdy=%b done=%b required 1 1", ia.req0_ready, a_init_done);
        end
        @(negedge clk);
        a_clear_start = 1'b0;
        drive_a(0, 0, 0, '0, '0, '0);
        drive_a(1, 1, 0, 9'h020, '0, '0);
        #1;
        checks++;
        if ({ia.rsp0_valid, ia.rsp_rdata} !== {1'b1, 72'hDEAD}) begin
            errors++;
            $display("FAIL clear_cmd_inflight rsp0=%b data=%h required 1 dead", ia.rsp0_valid, ia.rsp_rdata);
        end
        check_clear_sweep("clear_cmd");
        checks++;
        if (ia.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_cmd_run_ready got %b required 1", ia.req1_ready);
        end
        @(negedge clk);
        drive_a(1, 0, 0, '0, '0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency2();
        for (int i = 0; i < 3; i++) begin
            drive_b(1, 1, 1, AW'(3 + i), 72'h333 + DW'(i) * 72'h111, '1);
            @(negedge clk);
        end
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 3) drive_b(1, 1, 0, AW'(3 + j), '0, '0);
            else       drive_b(1, 0, 0, '0, '0, '0);
            #1;
            checks++;
            if ({b_reg_en, ib.rsp1_valid, ib.rsp0_valid} !== {(j >= 1 && j <= 3), (j >= 2 && j <= 4), 1'b0}) begin
                errors++;
                $display("FAIL lat2 j=%0d reg_en=%b rsp1=%b rsp0=%b required %b %b 0", j, b_reg_en, ib.rsp1_valid,
                         ib.rsp0_valid, (j >= 1 && j <= 3), (j >= 2 && j <= 4));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        a_clear_start = 1'b1;
        @(negedge clk);
        a_clear_start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 99)  drive_b(0, 1, 0, 9'h004, '0, '0);
            if (k == 100) drive_b(0, 0, 0, '0, '0, '0);
        end
        #1;
        checks++;
        if ({a_chip_en, a_addr, b_reg_en} !== {1'b1, 9'd100, 1'b1}) begin
            errors++;
            $display("FAIL mid_clear_pre en=%b addr=%0d b_reg=%b required 1 100 1", a_chip_en, a_addr, b_reg_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_chip_en, a_wr_en, ia.req0_ready, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid, a_init_done,
             b_reg_en, ib.rsp0_valid, b_init_done} !== 10'b0000000_001) begin
            errors++;
            $display("FAIL mid_clear_reset a_en=%b a_we=%b a_rdy=%b%b a_rsp=%b%b a_done=%b b_reg=%b b_rsp0=%b b_done=%b required zeros, b_done=1",
                     a_chip_en, a_wr_en, ia.req0_ready, ia.req1_ready, ia.rsp0_valid, ia.rsp1_valid, a_init_done,
                     b_reg_en, ib.rsp0_valid, b_init_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_clear_sweep("mid_clear");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_write_read();
        test_contention();
        test_latency2();
        test_clear_cmd();
        test_reset_mid_clear();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses a=%0d b=%0d required 0 0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
